// File: rtl/mem_wb.sv
// MEM->WB pipeline register: latches the GPR and HI/LO write results for write-back,
// honouring stall/flush from ctrl, and counts retired GPR writes.
module mem_wb #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned STALL_W = 6,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  w_reg_addr_in,
    input  logic [DATA_W-1:0]  w_reg_data_in,
    input  logic               w_reg_en_in,
    input  logic               w_hilo_en_in,
    input  logic [DATA_W-1:0]  hi_in,
    input  logic [DATA_W-1:0]  lo_in,
    output logic [ADDR_W-1:0]  w_reg_addr_out,
    output logic [DATA_W-1:0]  w_reg_data_out,
    output logic               w_reg_en_out,
    output logic               w_hilo_en_out,
    output logic [DATA_W-1:0]  hi_out,
    output logic [DATA_W-1:0]  lo_out,
    output logic [CNT_W-1:0]   retire_cnt
);

    logic mem_stall;
    logic wb_stall;
    logic bubble;
    logic capture;

    assign mem_stall = stall[4];
    assign wb_stall  = stall[5];

    // MEM stalled with WB free must drain a bubble, otherwise WB would repeat the write.
    // stall[4]=0 captures regardless of stall[5].
    always_comb begin
        bubble  = 1'b0;
        capture = 1'b0;
        if (flush) begin
            bubble = 1'b1;
        end else if (mem_stall && !wb_stall) begin
            bubble = 1'b1;
        end else if (!mem_stall) begin
            capture = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg_addr_out <= '0;
            w_reg_data_out <= '0;
            w_reg_en_out   <= 1'b0;
            w_hilo_en_out  <= 1'b0;
            hi_out         <= '0;
            lo_out         <= '0;
        end else if (bubble) begin
            w_reg_addr_out <= '0;
            w_reg_data_out <= '0;
            w_reg_en_out   <= 1'b0;
            w_hilo_en_out  <= 1'b0;
            hi_out         <= '0;
            lo_out         <= '0;
        end else if (capture) begin
            w_reg_addr_out <= w_reg_addr_in;
            w_reg_data_out <= w_reg_data_in;
            w_reg_en_out   <= w_reg_en_in;
            w_hilo_en_out  <= w_hilo_en_in;
            hi_out         <= hi_in;
            lo_out         <= lo_in;
        end
    end

    // Free-running, wraps at 2^CNT_W; writes to r0 still count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (capture && w_reg_en_in) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: a reference model pushes expected outputs to a queue per cycle,
// which are popped and compared after each rising edge. A 4-bit counter instance checks wrap.
module tb_mem_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  a_in;
    logic [31:0] d_in;
    logic        en_in;
    logic        hen_in;
    logic [31:0] hi_in;
    logic [31:0] lo_in;

    logic [4:0]  a_out;
    logic [31:0] d_out;
    logic        en_out;
    logic        hen_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] cnt;

    logic [4:0]  s_a_out;
    logic [31:0] s_d_out;
    logic        s_en_out;
    logic        s_hen_out;
    logic [31:0] s_hi_out;
    logic [31:0] s_lo_out;
    logic [3:0]  s_cnt;

    always #5 clk = ~clk;

    mem_wb dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .w_reg_addr_in(a_in), .w_reg_data_in(d_in), .w_reg_en_in(en_in),
        .w_hilo_en_in(hen_in), .hi_in(hi_in), .lo_in(lo_in),
        .w_reg_addr_out(a_out), .w_reg_data_out(d_out), .w_reg_en_out(en_out),
        .w_hilo_en_out(hen_out), .hi_out(hi_out), .lo_out(lo_out), .retire_cnt(cnt)
    );

    mem_wb #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .w_reg_addr_in(a_in), .w_reg_data_in(d_in), .w_reg_en_in(en_in),
        .w_hilo_en_in(hen_in), .hi_in(hi_in), .lo_in(lo_in),
        .w_reg_addr_out(s_a_out), .w_reg_data_out(s_d_out), .w_reg_en_out(s_en_out),
        .w_hilo_en_out(s_hen_out), .hi_out(s_hi_out), .lo_out(s_lo_out), .retire_cnt(s_cnt)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        en;
        logic        hen;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cnt;
        logic [3:0]  cnt_s;
    } exp_t;

    exp_t model;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        check({tag, ".addr"},  {27'd0, a_out},   {27'd0, e.addr});
        check({tag, ".data"},  d_out,            e.data);
        check({tag, ".en"},    {31'd0, en_out},  {31'd0, e.en});
        check({tag, ".hen"},   {31'd0, hen_out}, {31'd0, e.hen});
        check({tag, ".hi"},    hi_out,           e.hi);
        check({tag, ".lo"},    lo_out,           e.lo);
        check({tag, ".cnt"},   cnt,              e.cnt);
        check({tag, ".cnt_s"}, {28'd0, s_cnt},   {28'd0, e.cnt_s});
    endtask

    // Drive one cycle of stimulus at the falling edge, predict, then compare after the rise.
    task automatic step(input string tag, input logic [5:0] st, input logic fl,
                        input logic [4:0] a, input logic [31:0] d, input logic en,
                        input logic hen, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        @(negedge clk);
        stall = st; flush = fl; a_in = a; d_in = d; en_in = en;
        hen_in = hen; hi_in = hi; lo_in = lo;
        if (fl || (st[4] && !st[5])) begin
            model.addr = '0; model.data = '0; model.en = 1'b0;
            model.hen = 1'b0; model.hi = '0; model.lo = '0;
        end else if (!st[4]) begin
            model.addr = a; model.data = d; model.en = en;
            model.hen = hen; model.hi = hi; model.lo = lo;
            if (en) begin
                model.cnt   = model.cnt + 32'd1;
                model.cnt_s = model.cnt_s + 4'd1;
            end
        end
        sb.push_back(model);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare_all(tag, e);
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z = '0;
        compare_all(tag, z);
    endtask

    initial begin
        model = '0;
        // Reset with non-zero inputs applied.
        rst_n = 1'b0; stall = 6'd0; flush = 1'b0; a_in = 5'd17; d_in = 32'hCAFEF00D;
        en_in = 1'b1; hen_in = 1'b1; hi_in = 32'h11; lo_in = 32'h22;
        @(posedge clk); #1;
        check_zero("reset_hold");
        rst_n = 1'b1;

        step("capture",  6'b00_0000, 1'b0, 5'd3, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 32'h0);
        step("bubble",   6'b01_1111, 1'b0, 5'd7, 32'h0BAD0BAD, 1'b1, 1'b1, 32'h5, 32'h6);
        step("cap2",     6'b00_0000, 1'b0, 5'd9, 32'h12345678, 1'b1, 1'b1, 32'hAA, 32'hBB);
        for (int i = 0; i < 3; i++) begin
            step("hold", 6'b11_1111, 1'b0, 5'(i + 20), 32'hFFFF0000 + 32'(i), 1'b1, 1'b0,
                 32'h77, 32'h88);
        end
        step("flush_hold", 6'b11_1111, 1'b1, 5'd4, 32'h44444444, 1'b1, 1'b1, 32'h9, 32'h9);
        step("hilo",     6'b00_0000, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h1, 32'h2);
        step("illegal",  6'b10_0000, 1'b0, 5'd12, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 32'h0);
        step("flush_run", 6'b00_0000, 1'b1, 5'd13, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h0, 32'h0);
        step("addr0",    6'b00_0000, 1'b0, 5'd0, 32'h00000042, 1'b1, 1'b0, 32'h0, 32'h0);
        step("cap3",     6'b00_0000, 1'b0, 5'd31, 32'h87654321, 1'b1, 1'b1, 32'h3, 32'h4);

        // Asynchronous reset pulsed between edges with a live entry held.
        @(negedge clk);
        a_in = 5'd25; d_in = 32'h13579BDF; en_in = 1'b1; stall = 6'd0;
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(posedge clk); #1;
        check_zero("reset_low_edge");
        rst_n = 1'b1;
        model = '0;

        // Enough retiring writes to wrap the 4-bit counter instance past 15 -> 0.
        for (int i = 0; i < 18; i++) begin
            step("wrap", 6'b00_0000, 1'b0, 5'($urandom_range(31)), $urandom, 1'b1, 1'b0,
                 32'h0, 32'h0);
            if (i == 15) check("wrap_zero", {28'd0, s_cnt}, 32'd0);
        end
        step("post_wrap_idle", 6'b00_0000, 1'b0, 5'd1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);

        if (sb.size() != 0) begin
            check("sb_empty", 32'(sb.size()), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
